// File: rtl/move_validator.sv
// move_validator: registered move checker and owner of the NCELLS-cell board.
// Latency 1 cycle: a request sampled on an edge updates board, pulses, err_code
// and err_count on that same edge. Rejected requests leave board/turn untouched.
// Optional: define STRICT_TURN_EN to reject out-of-turn requests with code 4.
// Ports:
//   i_clock, i_reset          rising-edge clock, synchronous active-high reset
//   i_p_enable, i_c_enable    one-hot player / computer cell select (0 = idle)
//   i_board_clear             synchronous new-game clear, beats any request
//   o_board_flat              cell i at [2i+1:2i]: 00 empty, 01 player, 10 computer
//   o_move_valid, o_wrong_move  one-cycle commit / reject pulses
//   o_err_code                cause of last rejection, held until next request
//   o_err_count               saturating rejection count
//   o_turn, o_board_full      side to move, all cells occupied
module move_validator #(
  parameter int NCELLS    = 9,
  parameter int ERR_CNT_W = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NCELLS-1:0]      i_p_enable,
  input  logic [NCELLS-1:0]      i_c_enable,
  input  logic                   i_board_clear,
  output logic [2*NCELLS-1:0]    o_board_flat,
  output logic                   o_move_valid,
  output logic                   o_wrong_move,
  output logic [2:0]             o_err_code,
  output logic [ERR_CNT_W-1:0]   o_err_count,
  output logic                   o_turn,
  output logic                   o_board_full
);

  typedef enum logic [1:0] {
    P_TURN = 2'd0,
    C_TURN = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t                r_state;
  logic [2*NCELLS-1:0]   r_board;
  logic                  r_move_valid;
  logic                  r_wrong_move;
  logic [2:0]            r_err_code;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic                  r_turn;

  logic [NCELLS-1:0]     w_occ;
  logic [NCELLS-1:0]     w_req_vec;
  logic                  w_req;
  logic                  w_is_player;
  logic                  w_out_of_turn;
  logic [2:0]            w_err;
  logic                  w_fills;
  logic [2*NCELLS-1:0]   w_next_board;

  // Player request takes the vector slot when both sides are nonzero; that case
  // is rejected with code 3 before the vector contents matter.
  assign w_req       = (|i_p_enable) || (|i_c_enable);
  assign w_is_player = |i_p_enable;
  assign w_req_vec   = w_is_player ? i_p_enable : i_c_enable;

`ifdef STRICT_TURN_EN
  assign w_out_of_turn = (w_is_player && (r_state == C_TURN)) ||
                         (!w_is_player && (r_state == P_TURN));
`else
  assign w_out_of_turn = 1'b0;
`endif

  always_comb begin
    w_occ        = '0;
    w_next_board = r_board;
    for (int i = 0; i < NCELLS; i++) begin
      w_occ[i] = |r_board[2*i +: 2];
      if (w_req_vec[i]) begin
        w_next_board[2*i +: 2] = w_is_player ? 2'b01 : 2'b10;
      end
    end
  end

  // Committing this move leaves no empty cell.
  assign w_fills = &(w_occ | w_req_vec);

  // Error priority, highest first.
  always_comb begin
    w_err = 3'd0;
    if (r_state == FULL)                       w_err = 3'd5;
    else if ((|i_p_enable) && (|i_c_enable))   w_err = 3'd3;
    else if (!$onehot(w_req_vec))              w_err = 3'd2;
    else if (w_out_of_turn)                    w_err = 3'd4;
    else if (|(w_occ & w_req_vec))             w_err = 3'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_board_clear) begin
      r_state      <= P_TURN;
      r_board      <= '0;
      r_move_valid <= 1'b0;
      r_wrong_move <= 1'b0;
      r_err_code   <= 3'd0;
      r_err_count  <= '0;
      r_turn       <= 1'b0;
    end else if (!w_req) begin
      r_move_valid <= 1'b0;
      r_wrong_move <= 1'b0;
    end else if (w_err != 3'd0) begin
      r_move_valid <= 1'b0;
      r_wrong_move <= 1'b1;
      r_err_code   <= w_err;
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end else begin
      r_move_valid <= 1'b1;
      r_wrong_move <= 1'b0;
      r_err_code   <= 3'd0;
      r_board      <= w_next_board;
      r_turn       <= w_is_player;
      if (w_fills)          r_state <= FULL;
      else if (w_is_player) r_state <= C_TURN;
      else                  r_state <= P_TURN;
    end
  end

  assign o_board_flat = r_board;
  assign o_move_valid = r_move_valid;
  assign o_wrong_move = r_wrong_move;
  assign o_err_code   = r_err_code;
  assign o_err_count  = r_err_count;
  assign o_turn       = r_turn;
  assign o_board_full = &w_occ;

endmodule

// File: tb/tb_move_validator.sv
module tb_move_validator;

  localparam int N = 9;

  logic          clock;
  logic          reset;
  logic [N-1:0]  p_en;
  logic [N-1:0]  c_en;
  logic          clr;

  logic [2*N-1:0] board_a, board_b;
  logic           mv_a, mv_b, wm_a, wm_b, turn_a, turn_b, full_a, full_b;
  logic [2:0]     code_a, code_b;
  logic [3:0]     cnt_a;
  logic [1:0]     cnt_b;

  int vectors;
  int miscompares;

  move_validator #(.NCELLS(N), .ERR_CNT_W(4)) dut (
    .i_clock(clock), .i_reset(reset), .i_p_enable(p_en), .i_c_enable(c_en),
    .i_board_clear(clr), .o_board_flat(board_a), .o_move_valid(mv_a),
    .o_wrong_move(wm_a), .o_err_code(code_a), .o_err_count(cnt_a),
    .o_turn(turn_a), .o_board_full(full_a)
  );

  move_validator #(.NCELLS(N), .ERR_CNT_W(2)) dut_w2 (
    .i_clock(clock), .i_reset(reset), .i_p_enable(p_en), .i_c_enable(c_en),
    .i_board_clear(clr), .o_board_flat(board_b), .o_move_valid(mv_b),
    .o_wrong_move(wm_b), .o_err_code(code_b), .o_err_count(cnt_b),
    .o_turn(turn_b), .o_board_full(full_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2*N-1:0] board;
    logic           mv;
    logic           wm;
    logic [2:0]     code;
    logic [3:0]     cnt;
    logic [1:0]     cnt2;
    logic           turn;
    logic           full;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0] m_cell [N];
  logic       m_turn;
  logic       m_locked;
  logic [2:0] m_code;
  int         m_cnt;
  int         m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic [N-1:0] p, input logic [N-1:0] c,
                      input logic cl, input logic rs);
    exp_t       e;
    logic [N-1:0] v;
    logic       player;
    logic [2:0] code;
    int         ones;
    e.mv = 1'b0;
    e.wm = 1'b0;
    if (rs || cl) begin
      for (int i = 0; i < N; i++) m_cell[i] = 2'b00;
      m_turn = 1'b0; m_locked = 1'b0; m_code = 3'd0; m_cnt = 0; m_cnt2 = 0;
    end else if (p != 0 || c != 0) begin
      player = (p != 0);
      v = player ? p : c;
      ones = $countones(v);
      code = 3'd0;
      if (m_locked) code = 3'd5;
      else if (p != 0 && c != 0) code = 3'd3;
      else if (ones != 1) code = 3'd2;
`ifdef STRICT_TURN_EN
      else if (player == m_turn) code = 3'd4;
`endif
      else begin
        for (int i = 0; i < N; i++)
          if (v[i] && m_cell[i] != 2'b00) code = 3'd1;
      end
      m_code = code;
      if (code != 0) begin
        e.wm = 1'b1;
        if (m_cnt < 15) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else begin
        e.mv = 1'b1;
        for (int i = 0; i < N; i++)
          if (v[i]) m_cell[i] = player ? 2'b01 : 2'b10;
        m_turn = player;
        m_locked = 1'b1;
        for (int i = 0; i < N; i++)
          if (m_cell[i] == 2'b00) m_locked = 1'b0;
      end
    end
    e.full = 1'b1;
    for (int i = 0; i < N; i++) begin
      e.board[2*i +: 2] = m_cell[i];
      if (m_cell[i] == 2'b00) e.full = 1'b0;
    end
    e.code = m_code;
    e.cnt  = 4'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    e.turn = m_turn;
    sb.push_back(e);

    p_en = p; c_en = c; clr = cl; reset = rs;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("board",      32'(board_a), 32'(e.board));
    check("move_valid", 32'(mv_a),    32'(e.mv));
    check("wrong_move", 32'(wm_a),    32'(e.wm));
    check("err_code",   32'(code_a),  32'(e.code));
    check("err_count",  32'(cnt_a),   32'(e.cnt));
    check("turn",       32'(turn_a),  32'(e.turn));
    check("board_full", 32'(full_a),  32'(e.full));
    check("err_count_w2", 32'(cnt_b), 32'(e.cnt2));
    check("board_w2",   32'(board_b), 32'(e.board));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rp, rc, one;
    vectors = 0;
    miscompares = 0;
    p_en = '0; c_en = '0; clr = 1'b0; reset = 1'b1;
    for (int i = 0; i < N; i++) m_cell[i] = 2'b00;
    m_turn = 0; m_locked = 0; m_code = 0; m_cnt = 0; m_cnt2 = 0;
    @(posedge clock); #1;

    step('0, '0, 1'b0, 1'b1);                    // reset state
    step(9'b000010000, '0, 1'b0, 1'b0);          // player takes cell 4
    step('0, 9'b000010000, 1'b0, 1'b0);          // occupied -> 1
    step('0, '0, 1'b0, 1'b0);                    // idle: pulses drop, code held
    step(9'b000000011, '0, 1'b0, 1'b0);          // not one-hot -> 2
    step(9'b000000001, 9'b000000010, 1'b0, 1'b0);// both sides -> 3
    step('0, '0, 1'b1, 1'b0);                    // clear
    step('0, 9'b000000001, 1'b0, 1'b0);          // code 4 when strict, else commit
    step('0, '0, 1'b1, 1'b0);

    // Fill the board with alternating legal moves.
    for (int i = 0; i < N; i++) begin
      one = '0;
      one[i] = 1'b1;
      if (i % 2 == 0) step(one, '0, 1'b0, 1'b0);
      else            step('0, one, 1'b0, 1'b0);
    end
    // Rejections while full: code 5, counter saturation on both widths.
    for (int i = 0; i < 18; i++) step(9'b000000001, '0, 1'b0, 1'b0);
    step('0, 9'b000000100, 1'b0, 1'b0);
    step(9'b000000001, '0, 1'b1, 1'b0);          // clear beats request

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      rp = '0; rc = '0;
      case ($urandom_range(0, 5))
        0: rp[$urandom_range(0, N-1)] = 1'b1;
        1: rc[$urandom_range(0, N-1)] = 1'b1;
        2: rp = N'($urandom);
        3: begin rp[$urandom_range(0, N-1)] = 1'b1; rc[$urandom_range(0, N-1)] = 1'b1; end
        default: ;
      endcase
      step(rp, rc, ($urandom_range(0, 19) == 0), 1'b0);
    end
    step(9'b000000010, '0, 1'b0, 1'b1);          // reset beats request

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
